// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: parametrised integer register file with hardwired zero
// register and a per-register busy scoreboard for a pipelined core.
//
// Decode reads operands and busy flags combinationally and marks its
// destination register pending at issue; writeback writes the result and
// clears the pending mark.
//
// Optional feature: define REGFILE_WB_BYPASS_EN to forward same-cycle
// writeback data onto the read ports (write-through). Default build has no
// forwarding: new data is visible from the cycle after the write edge.
//
// Ports:
//   clk          core clock, all state updates on rising edge
//   reset        synchronous active-low reset
//   rd_addr      NRD packed read addresses, port k at [k*AW +: AW]
//   rd_data      NRD packed read data, port k at [k*XLEN +: XLEN]
//   rd_busy      busy flag of the register addressed on each read port
//   iss_valid    issue strobe, marks iss_rd pending
//   iss_rd       destination register being issued
//   wb_en        writeback strobe
//   wb_rd        writeback destination register
//   wb_data      writeback data
//   pending_cnt  registered count of busy registers
//   all_idle     1 when no register is busy
//   print_reg    flattened register contents (debug), reg i at [i*XLEN +: XLEN]
module regfile_scoreboard #(
  parameter int              XLEN    = 32,
  parameter int              NREG    = 32,
  parameter int              NRD     = 2,
  parameter int              SP_IDX  = 2,
  parameter logic [XLEN-1:0] SP_INIT = 32'h2ffc
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NRD*$clog2(NREG)-1:0]   rd_addr,
  output logic [NRD*XLEN-1:0]           rd_data,
  output logic [NRD-1:0]                rd_busy,
  input  logic                          iss_valid,
  input  logic [$clog2(NREG)-1:0]       iss_rd,
  input  logic                          wb_en,
  input  logic [$clog2(NREG)-1:0]       wb_rd,
  input  logic [XLEN-1:0]               wb_data,
  output logic [$clog2(NREG):0]         pending_cnt,
  output logic                          all_idle,
  output logic [NREG*XLEN-1:0]          print_reg
);

  localparam int AW = $clog2(NREG);

  logic [XLEN-1:0] rf [NREG];
  logic [NREG-1:0] busy;
  logic [NREG-1:0] busy_next;
  logic [AW:0]     cnt_q;
  logic            wb_write;

  function automatic logic [AW:0] popcount(input logic [NREG-1:0] v);
    logic [AW:0] c;
    c = '0;
    for (int i = 0; i < NREG; i++) begin
      c = c + {{AW{1'b0}}, v[i]};
    end
    return c;
  endfunction

  assign wb_write = wb_en && (wb_rd != '0);

  // Issue takes priority over writeback on the same register: the newly
  // issued producer is still outstanding even though an older result landed.
  always_comb begin
    busy_next = busy;
    for (int r = 1; r < NREG; r++) begin
      if (iss_valid && (iss_rd == AW'(r))) begin
        busy_next[r] = 1'b1;
      end else if (wb_en && (wb_rd == AW'(r))) begin
        busy_next[r] = 1'b0;
      end
    end
    busy_next[0] = 1'b0;
  end

  // State update: register file, busy bits and the registered busy count
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NREG; i++) begin
        rf[i] <= (i == SP_IDX) ? SP_INIT : '0;
      end
      busy  <= '0;
      cnt_q <= '0;
    end else begin
      if (wb_write) begin
        rf[wb_rd] <= wb_data;
      end
      busy  <= busy_next;
      cnt_q <= popcount(busy_next);
    end
  end

  assign pending_cnt = cnt_q;
  assign all_idle    = (cnt_q == '0);

  // Combinational read ports
  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0]   addr;
    logic [XLEN-1:0] data;
    logic            bsy;

    assign addr = rd_addr[k*AW +: AW];

    always_comb begin
      data = '0;
      bsy  = 1'b0;
      if (addr != '0) begin
`ifdef REGFILE_WB_BYPASS_EN
        if (wb_write && (addr == wb_rd)) begin
          data = wb_data;
          bsy  = iss_valid && (iss_rd == wb_rd);
        end else begin
          data = rf[addr];
          bsy  = busy[addr];
        end
`else
        data = rf[addr];
        bsy  = busy[addr];
`endif
      end
    end

    assign rd_data[k*XLEN +: XLEN] = data;
    assign rd_busy[k]              = bsy;
  end

  // Debug mirror; slot 0 is forced to zero like the architectural register
  assign print_reg[XLEN-1:0] = '0;
  for (genvar i = 1; i < NREG; i++) begin : g_print
    assign print_reg[i*XLEN +: XLEN] = rf[i];
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Self-checking bench for regfile_scoreboard (default parameters, NRD=2).
// Vectors are applied on the falling edge; combinational reads are checked
// just before the rising edge, registered count/idle just after it.
module tb_regfile_scoreboard;

  logic         clk = 1'b0;
  logic         reset;
  logic [9:0]   rd_addr;
  logic [63:0]  rd_data;
  logic [1:0]   rd_busy;
  logic         iss_valid;
  logic [4:0]   iss_rd;
  logic         wb_en;
  logic [4:0]   wb_rd;
  logic [31:0]  wb_data;
  logic [5:0]   pending_cnt;
  logic         all_idle;
  logic [1023:0] print_reg;

  int total = 0;
  int passed = 0;

  always #5 clk = ~clk;

  regfile_scoreboard dut (
    .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data),
    .rd_busy(rd_busy), .iss_valid(iss_valid), .iss_rd(iss_rd),
    .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
    .pending_cnt(pending_cnt), .all_idle(all_idle), .print_reg(print_reg)
  );

  typedef struct {
    logic        iv;
    logic [4:0]  ird;
    logic        we;
    logic [4:0]  wrd;
    logic [31:0] wd;
    logic [4:0]  a0;
    logic [4:0]  a1;
    logic [31:0] ed0;
    logic        eb0;
    logic [31:0] ed1;
    logic        eb1;
    logic [5:0]  ecnt;
    logic        eidle;
  } vec_t;

  typedef struct packed {
    logic [5:0] cnt;
    logic       idle;
  } exp_t;

  vec_t tbl[14];
  exp_t sbq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      passed++;
    end
  endtask

  task automatic drive(input logic iv, input logic [4:0] ird, input logic we,
                       input logic [4:0] wrd, input logic [31:0] wd,
                       input logic [4:0] a0, input logic [4:0] a1);
    iss_valid = iv;
    iss_rd    = ird;
    wb_en     = we;
    wb_rd     = wrd;
    wb_data   = wd;
    rd_addr   = {a1, a0};
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    drive(1'b0, 5'd0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
    tick();
  endtask

  initial begin
    exp_t e;

    // {iv, ird, we, wrd, wd, a0, a1, ed0, eb0, ed1, eb1, cnt_after, idle_after}
    tbl[0]  = '{1'b0, 5'd0, 1'b1, 5'd5,  32'hdeadbeef, 5'd2, 5'd0, 32'h2ffc,     1'b0, 32'h0,        1'b0, 6'd0, 1'b1};
    tbl[1]  = '{1'b0, 5'd0, 1'b1, 5'd0,  32'h1234,     5'd5, 5'd0, 32'hdeadbeef, 1'b0, 32'h0,        1'b0, 6'd0, 1'b1};
    tbl[2]  = '{1'b1, 5'd7, 1'b0, 5'd0,  32'h0,        5'd0, 5'd5, 32'h0,        1'b0, 32'hdeadbeef, 1'b0, 6'd1, 1'b0};
    tbl[3]  = '{1'b1, 5'd9, 1'b0, 5'd0,  32'h0,        5'd7, 5'd9, 32'h0,        1'b1, 32'h0,        1'b0, 6'd2, 1'b0};
    tbl[4]  = '{1'b0, 5'd0, 1'b1, 5'd7,  32'h77,       5'd9, 5'd5, 32'h0,        1'b1, 32'hdeadbeef, 1'b0, 6'd1, 1'b0};
    tbl[5]  = '{1'b0, 5'd0, 1'b1, 5'd9,  32'h99,       5'd7, 5'd3, 32'h77,       1'b0, 32'h0,        1'b0, 6'd0, 1'b1};
    tbl[6]  = '{1'b1, 5'd3, 1'b0, 5'd0,  32'h0,        5'd9, 5'd7, 32'h99,       1'b0, 32'h77,       1'b0, 6'd1, 1'b0};
    tbl[7]  = '{1'b1, 5'd3, 1'b1, 5'd3,  32'h55,       5'd9, 5'd2, 32'h99,       1'b0, 32'h2ffc,     1'b0, 6'd1, 1'b0};
    tbl[8]  = '{1'b0, 5'd0, 1'b0, 5'd0,  32'h0,        5'd3, 5'd0, 32'h55,       1'b1, 32'h0,        1'b0, 6'd1, 1'b0};
    tbl[9]  = '{1'b1, 5'd0, 1'b0, 5'd0,  32'h0,        5'd3, 5'd0, 32'h55,       1'b1, 32'h0,        1'b0, 6'd1, 1'b0};
    tbl[10] = '{1'b0, 5'd0, 1'b1, 5'd3,  32'h56,       5'd0, 5'd0, 32'h0,        1'b0, 32'h0,        1'b0, 6'd0, 1'b1};
    tbl[11] = '{1'b1, 5'd0, 1'b0, 5'd0,  32'h0,        5'd3, 5'd0, 32'h56,       1'b0, 32'h0,        1'b0, 6'd0, 1'b1};
    tbl[12] = '{1'b0, 5'd0, 1'b1, 5'd11, 32'h11,       5'd0, 5'd0, 32'h0,        1'b0, 32'h0,        1'b0, 6'd0, 1'b1};
    tbl[13] = '{1'b0, 5'd0, 1'b0, 5'd0,  32'h0,        5'd11, 5'd11, 32'h11,     1'b0, 32'h11,       1'b0, 6'd0, 1'b1};

    // Reset held for two cycles
    reset = 1'b0;
    drive(1'b0, 5'd0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
    tick();
    tick();
    @(negedge clk);
    reset = 1'b1;
    #1;
    for (int i = 0; i < 32; i++) begin
      chk($sformatf("reset_rf%0d", i), print_reg[i*32 +: 32], (i == 2) ? 32'h2ffc : 32'h0);
    end
    chk("reset_cnt", {26'b0, pending_cnt}, 32'd0);
    chk("reset_idle", {31'b0, all_idle}, 32'd1);

    // Table-driven vectors with scoreboard for registered outputs
    for (int v = 0; v < 14; v++) begin
      @(negedge clk);
      drive(tbl[v].iv, tbl[v].ird, tbl[v].we, tbl[v].wrd, tbl[v].wd, tbl[v].a0, tbl[v].a1);
      sbq.push_back('{cnt: tbl[v].ecnt, idle: tbl[v].eidle});
      #1;
      chk($sformatf("v%0d_rd_data0", v), rd_data[31:0],  tbl[v].ed0);
      chk($sformatf("v%0d_rd_busy0", v), {31'b0, rd_busy[0]}, {31'b0, tbl[v].eb0});
      chk($sformatf("v%0d_rd_data1", v), rd_data[63:32], tbl[v].ed1);
      chk($sformatf("v%0d_rd_busy1", v), {31'b0, rd_busy[1]}, {31'b0, tbl[v].eb1});
      tick();
      e = sbq.pop_front();
      chk($sformatf("v%0d_pending_cnt", v), {26'b0, pending_cnt}, {26'b0, e.cnt});
      chk($sformatf("v%0d_all_idle", v), {31'b0, all_idle}, {31'b0, e.idle});
    end
    chk("rf3_after_simul", print_reg[3*32 +: 32], 32'h56);
    chk("rf0_never_written", print_reg[31:0], 32'h0);

    // Reset mid-operation: regs 4 and 6 busy, rf[4]=0x10
    @(negedge clk);
    drive(1'b0, 5'd0, 1'b1, 5'd4, 32'h10, 5'd0, 5'd0);
    tick();
    @(negedge clk);
    drive(1'b1, 5'd4, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
    tick();
    @(negedge clk);
    drive(1'b1, 5'd6, 1'b0, 5'd0, 32'h0, 5'd4, 5'd6);
    tick();
    chk("mid_cnt_before", {26'b0, pending_cnt}, 32'd2);
    chk("mid_rf4_before", print_reg[4*32 +: 32], 32'h10);
    @(negedge clk);
    reset = 1'b0;
    drive(1'b1, 5'd8, 1'b1, 5'd4, 32'hff, 5'd4, 5'd6);
    tick();
    chk("mid_rf4_after", print_reg[4*32 +: 32], 32'h0);
    chk("mid_sp_after", print_reg[2*32 +: 32], 32'h2ffc);
    chk("mid_cnt_after", {26'b0, pending_cnt}, 32'd0);
    chk("mid_idle_after", {31'b0, all_idle}, 32'd1);
    chk("mid_busy_after", {30'b0, rd_busy}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    drive(1'b0, 5'd0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
    tick();

    // Bypass: reg 8 starts at 0x01, then same-cycle write and read
    @(negedge clk);
    drive(1'b0, 5'd0, 1'b1, 5'd8, 32'h1, 5'd0, 5'd0);
    tick();
    @(negedge clk);
    drive(1'b0, 5'd0, 1'b1, 5'd8, 32'ha5a5a5a5, 5'd0, 5'd8);
    #1;
`ifdef REGFILE_WB_BYPASS_EN
    chk("byp_same_cycle_data", rd_data[63:32], 32'ha5a5a5a5);
`else
    chk("byp_same_cycle_data", rd_data[63:32], 32'h1);
`endif
    chk("byp_same_cycle_busy", {31'b0, rd_busy[1]}, 32'd0);
    chk("byp_port0_zero", rd_data[31:0], 32'h0);
    tick();
    @(negedge clk);
    drive(1'b0, 5'd0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd8);
    #1;
    chk("byp_next_cycle_data", rd_data[63:32], 32'ha5a5a5a5);
    tick();

    // Same-cycle issue and writeback to a read register
    @(negedge clk);
    drive(1'b1, 5'd8, 1'b1, 5'd8, 32'h5a5a, 5'd8, 5'd0);
    #1;
`ifdef REGFILE_WB_BYPASS_EN
    chk("byp_iss_data", rd_data[31:0], 32'h5a5a);
    chk("byp_iss_busy", {31'b0, rd_busy[0]}, 32'd1);
`else
    chk("byp_iss_data", rd_data[31:0], 32'ha5a5a5a5);
    chk("byp_iss_busy", {31'b0, rd_busy[0]}, 32'd0);
`endif
    tick();
    chk("byp_iss_rf8", print_reg[8*32 +: 32], 32'h5a5a);
    chk("byp_iss_cnt", {26'b0, pending_cnt}, 32'd1);
    idle_cycle();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/regfile_scoreboard.md
Name: regfile_scoreboard

Overview:
- Parametrised successor to the core's integer register file. Adds configurable width, depth and read-port count, a hardwired zero register, and a per-register busy scoreboard for a pipelined core.
- The decode stage reads operands and the busy flags, and marks its destination register pending at issue.
- Writeback writes the result and clears the pending mark.
- Sits between decode/issue and writeback in the pipelined CPU.

Parameters:
XLEN, 32, data width of each register
NREG, 32, number of registers (power of two, >= 4)
NRD, 2, number of asynchronous read ports
SP_IDX, 2, index of the stack-pointer register loaded at reset
SP_INIT, 32'h2ffc, stack-pointer reset value (XLEN bits)

Ports:
clk  input  1  core clock; all state updates on rising edge
reset  input  1  synchronous, active-low reset (asserted when 0)
rd_addr  input  NRD*AW  packed read addresses, port k at bits [k*AW +: AW], AW = $clog2(NREG)
rd_data  output  NRD*XLEN  packed read data, port k at [k*XLEN +: XLEN]
rd_busy  output  NRD  busy flag of the register addressed on each read port
iss_valid  input  1  issue strobe: mark iss_rd pending
iss_rd  input  AW  destination register being issued
wb_en  input  1  writeback strobe
wb_rd  input  AW  writeback destination register
wb_data  input  XLEN  writeback data
pending_cnt  output  AW+1  number of registers currently busy
all_idle  output  1  1 when no register is busy
print_reg  output  NREG*XLEN  flattened register contents, reg i at [i*XLEN +: XLEN], debug only

Behaviour:
- Reset is synchronous and active-low:
  - while reset==0 at a rising edge, all registers go to 0, except reg SP_IDX, which goes to SP_INIT;
  - all busy bits clear, pending_cnt=0, all_idle=1;
  - reset overrides iss_valid and wb_en in the same cycle.
- Reads are combinational, with no clock latency:
  - rd_data[k] = rf[rd_addr[k]];
  - rd_busy[k] = busy[rd_addr[k]];
  - address 0 always reads data 0 and busy 0.
- Write: when wb_en=1 and wb_rd!=0, rf[wb_rd] <= wb_data at the rising edge. Writes to reg 0 are discarded.
- Scoreboard, one busy bit per register, reg 0 never busy. Next state per register r:
  - iss_valid && iss_rd==r && r!=0 -> busy[r] <= 1;
  - else wb_en && wb_rd==r -> busy[r] <= 0;
  - else hold.
- Same-cycle issue and writeback to the same register: busy stays 1 (the new producer is outstanding) and the data write still occurs.
- Writeback to a non-busy register: data is written, and busy stays 0; this is not an error.
- Issue to an already-busy register: it stays busy. There is no counting per register; the newest writeback clears it.
- pending_cnt is registered and equals the popcount of the busy bits after the update (consistent with busy in the same cycle). It is at most NREG-1.
- all_idle = (pending_cnt==0).
- print_reg mirrors rf combinationally; reg 0 slot reads 0.
- With NRD=1, the upper port fields are absent. Any NRD>=1 must elaborate.

Optional Feature:
- Macro: REGFILE_WB_BYPASS_EN.
- Defined:
  - if wb_en=1, wb_rd!=0 and rd_addr[k]==wb_rd in the same cycle, rd_data[k]=wb_data and rd_busy[k]=0 (write-through forwarding);
  - exception: if iss_valid && iss_rd==wb_rd in that same cycle, rd_busy[k]=1;
  - read of address 0 is unaffected.
- Undefined:
  - reads return the stored value; new data is visible from the cycle after the write edge;
  - rd_busy reflects stored busy bits only.

Test Plan:
- Reset: hold reset=0 for 2 cycles, then release -> rf[2]=32'h2ffc, every other reg=0, pending_cnt=0, all_idle=1.
- Write and read back: wb_en=1, wb_rd=5, wb_data=32'hdeadbeef; next cycle rd_addr[0]=5 -> rd_data[0]=32'hdeadbeef. Then wb_rd=0, wb_data=32'h1234 -> reading reg 0 gives 0.
- Scoreboard flow:
  - issue rd=7 -> rd_busy=1 on reads of 7, pending_cnt=1;
  - issue rd=9 -> pending_cnt=2;
  - wb rd=7 -> busy[7]=0, pending_cnt=1;
  - wb rd=9 -> all_idle=1.
- Simultaneous events: busy[3]=1; same cycle iss_valid/iss_rd=3 and wb_en/wb_rd=3/wb_data=32'h55 -> rf[3]=32'h55, busy[3] stays 1, pending_cnt unchanged. Issue to reg 0 -> pending_cnt stays 0.
- Reset mid-operation: regs 4 and 6 busy, rf[4]=32'h10; apply reset=0 together with wb_en to reg 4 -> after the edge rf[4]=0, busy all 0, SP=32'h2ffc.
- Bypass, run both ways: wb_rd=8, wb_data=32'hA5A5A5A5, rd_addr[1]=8 in the same cycle:
  - with REGFILE_WB_BYPASS_EN -> rd_data[1]=32'hA5A5A5A5 that cycle;
  - without it -> old value that cycle, new value next cycle.
